pipe_hazard_ctrl: RTL and testbench

//  Sequences the IF/ID pipeline register and PC: issues hold (hazard), flush, PC-write and ID/EX bubble controls.

---
 rtl/pipe_hazard_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Purpose:
//   Front-end pipeline sequencer. Drives the IF/ID hold/flush controls, the
//   PC write enable and the ID/EX bubble insertion. It detects load-use
//   hazards, stretches taken-branch flushes over FLUSH_CYCLES cycles, freezes
//   the back half of the pipe while data memory is busy, flags excessive
//   memory waits and keeps saturating stall/flush statistics.
//
// Parameters:
//   FLUSH_CYCLES  cycles flush_o stays high per taken branch (1..15)
//   MEM_TIMEOUT   consecutive dmem_busy_i cycles before timeout_o sets (>=1)
//   CNT_W         width of the statistics counters
//
// Ports:
//   clk_i           rising-edge clock
//   rst_n_i         asynchronous active-low reset
//   start_i         core run enable (low = idle, clears timeout_o)
//   id_rs1_i/rs2_i  source registers of the instruction in ID
//   ex_memread_i    instruction in EX is a load
//   ex_rd_i         destination register of the instruction in EX
//   branch_taken_i  branch/jump resolved taken in ID this cycle
//   dmem_busy_i     data memory not ready, whole pipe must freeze
//   pc_write_o      PC update enable
//   hazard_o        IF/ID hold
//   flush_o         IF/ID flush
//   bubble_o        force NOP into ID/EX
//   freeze_o        hold ID/EX, EX/MEM, MEM/WB
//   timeout_o       sticky memory-wait timeout flag
//   stall_cnt_o     saturating count of stalled (PC held) running cycles
//   flush_cnt_o     saturating count of taken-branch flush events
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 64,
  parameter int CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             branch_taken_i,
  input  logic             dmem_busy_i,
  output logic             pc_write_o,
  output logic             hazard_o,
  output logic             flush_o,
  output logic             bubble_o,
  output logic             freeze_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int             TW             = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0]  TIMER_MAX      = TW'(MEM_TIMEOUT);
  localparam logic [3:0]     FLUSH_REM_INIT = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_MEM_WAIT = 2'd3
  } state_t;

  state_t            r_state;
  state_t            r_saved_state;   // state to resume once memory is ready
  logic [3:0]        r_flush_rem;     // flush cycles still owed after this one
  logic [TW-1:0]     r_busy_timer;
  logic              r_timeout;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  state_t            w_next_state;
  state_t            w_eff_state;
  logic              w_load_use;
  logic              w_take_branch;
  logic              w_flush_step;
  logic              w_stall;
  logic              w_busy_count;
  logic [TW-1:0]     w_timer_inc;

  // In MEM_WAIT the decode acts as the saved state, so when busy drops the
  // resumed RUN/FLUSH behaviour takes effect in that very cycle.
  assign w_eff_state = (r_state == ST_MEM_WAIT) ? r_saved_state : r_state;

  // x0 is hard-wired zero, so a load to it never creates a dependency.
  assign w_load_use = ex_memread_i && (ex_rd_i != 5'd0) &&
                      ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

  // Timer saturates at the timeout value so it cannot wrap on long waits.
  assign w_timer_inc = (r_busy_timer == TIMER_MAX) ? r_busy_timer
                                                   : r_busy_timer + TW'(1);

  always_comb begin
    pc_write_o    = 1'b0;
    hazard_o      = 1'b0;
    flush_o       = 1'b0;
    bubble_o      = 1'b0;
    freeze_o      = 1'b0;
    w_next_state  = r_state;
    w_take_branch = 1'b0;
    w_flush_step  = 1'b0;
    w_stall       = 1'b0;
    w_busy_count  = 1'b0;

    if (!start_i) begin
      w_next_state = ST_IDLE;
    end else if (r_state == ST_IDLE) begin
      w_next_state = ST_RUN;
    end else if (dmem_busy_i) begin
      // Freeze dominates: no bubble and no branch action while memory stalls.
      freeze_o     = 1'b1;
      hazard_o     = 1'b1;
      w_stall      = 1'b1;
      w_busy_count = 1'b1;
      w_next_state = ST_MEM_WAIT;
    end else if (w_eff_state == ST_FLUSH) begin
      // ID holds a flushed NOP, so neither load-use nor branches apply here.
      flush_o      = 1'b1;
      pc_write_o   = 1'b1;
      w_flush_step = 1'b1;
      w_next_state = (r_flush_rem <= 4'd1) ? ST_RUN : ST_FLUSH;
    end else if (w_load_use) begin
      hazard_o     = 1'b1;
      bubble_o     = 1'b1;
      w_stall      = 1'b1;
      w_next_state = ST_RUN;
    end else if (branch_taken_i) begin
      flush_o       = 1'b1;
      pc_write_o    = 1'b1;
      w_take_branch = 1'b1;
      w_next_state  = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
    end else begin
      pc_write_o   = 1'b1;
      w_next_state = ST_RUN;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state       <= ST_IDLE;
      r_saved_state <= ST_RUN;
      r_flush_rem   <= 4'd0;
      r_busy_timer  <= '0;
      r_timeout     <= 1'b0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      if (!start_i) begin
        // Stopping the core abandons any flush/wait; statistics are kept.
        r_flush_rem  <= 4'd0;
        r_busy_timer <= '0;
        r_timeout    <= 1'b0;
      end else begin
        // Capture the resume state only on the first frozen cycle.
        if (w_busy_count && (r_state != ST_MEM_WAIT)) begin
          r_saved_state <= r_state;
        end

        if (w_take_branch) begin
          r_flush_rem <= FLUSH_REM_INIT;
        end else if (w_flush_step) begin
          r_flush_rem <= r_flush_rem - 4'd1;
        end

        if (w_busy_count) begin
          r_busy_timer <= w_timer_inc;
          if (w_timer_inc == TIMER_MAX) begin
            r_timeout <= 1'b1;
          end
        end else begin
          r_busy_timer <= '0;
        end

        if (w_stall && !(&r_stall_cnt)) begin
          r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
        if (w_take_branch && !(&r_flush_cnt)) begin
          r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign timeout_o   = r_timeout;
  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed scenarios followed by random traffic, all compared cycle by cycle
// against a rule-level reference model (running flag, owed flush cycles,
// consecutive busy count, statistics). Small CNT_W makes counter saturation
// reachable within a short run.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int FC   = 3;
  localparam int MT   = 8;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          start_i;
  logic [4:0]    id_rs1_i;
  logic [4:0]    id_rs2_i;
  logic          ex_memread_i;
  logic [4:0]    ex_rd_i;
  logic          branch_taken_i;
  logic          dmem_busy_i;
  logic          pc_write_o;
  logic          hazard_o;
  logic          flush_o;
  logic          bubble_o;
  logic          freeze_o;
  logic          timeout_o;
  logic [CW-1:0] stall_cnt_o;
  logic [CW-1:0] flush_cnt_o;

  pipe_hazard_ctrl #(
    .FLUSH_CYCLES (FC),
    .MEM_TIMEOUT  (MT),
    .CNT_W        (CW)
  ) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .start_i        (start_i),
    .id_rs1_i       (id_rs1_i),
    .id_rs2_i       (id_rs2_i),
    .ex_memread_i   (ex_memread_i),
    .ex_rd_i        (ex_rd_i),
    .branch_taken_i (branch_taken_i),
    .dmem_busy_i    (dmem_busy_i),
    .pc_write_o     (pc_write_o),
    .hazard_o       (hazard_o),
    .flush_o        (flush_o),
    .bubble_o       (bubble_o),
    .freeze_o       (freeze_o),
    .timeout_o      (timeout_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fails  = 0;
  int flush_hi_seen = 0;

  // Reference model state, described in terms of the behavioural rules.
  bit m_running;
  int m_flush_left;   // flush cycles still owed to the current branch
  int m_busy_run;     // consecutive busy cycles while running
  bit m_timeout;
  int m_stall;
  int m_flush;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_running    = 1'b0;
    m_flush_left = 0;
    m_busy_run   = 0;
    m_timeout    = 1'b0;
    m_stall      = 0;
    m_flush      = 0;
  endtask

  task automatic drive(input bit st, input bit busy, input bit br, input bit mr,
                       input int rd, input int rs1, input int rs2);
    start_i        = st;
    dmem_busy_i    = busy;
    branch_taken_i = br;
    ex_memread_i   = mr;
    ex_rd_i        = 5'(rd);
    id_rs1_i       = 5'(rs1);
    id_rs2_i       = 5'(rs2);
  endtask

  // Called at posedge+1 with inputs already driven: checks the same-cycle
  // controls, advances the model over the edge, then checks registered state.
  task automatic tick();
    bit lu, br_event;
    bit e_pc, e_hz, e_fl, e_bb, e_fz;
    #1;
    lu = ex_memread_i && (ex_rd_i != 0) && (ex_rd_i == id_rs1_i || ex_rd_i == id_rs2_i);
    e_pc = 0; e_hz = 0; e_fl = 0; e_bb = 0; e_fz = 0;
    br_event = 0;
    if (start_i && m_running) begin
      if (dmem_busy_i) begin
        e_fz = 1; e_hz = 1;
      end else if (m_flush_left > 0) begin
        e_fl = 1; e_pc = 1;
      end else if (lu) begin
        e_hz = 1; e_bb = 1;
      end else if (branch_taken_i) begin
        e_fl = 1; e_pc = 1; br_event = 1;
      end else begin
        e_pc = 1;
      end
    end
    check("pc_write", 32'(pc_write_o), 32'(e_pc));
    check("hazard",   32'(hazard_o),   32'(e_hz));
    check("flush",    32'(flush_o),    32'(e_fl));
    check("bubble",   32'(bubble_o),   32'(e_bb));
    check("freeze",   32'(freeze_o),   32'(e_fz));
    if (flush_o === 1'b1) flush_hi_seen++;

    if (!start_i) begin
      m_running    = 0;
      m_flush_left = 0;
      m_busy_run   = 0;
      m_timeout    = 0;
    end else if (!m_running) begin
      m_running = 1;
    end else begin
      if (!e_pc && m_stall < CMAX) m_stall++;
      if (dmem_busy_i) begin
        m_busy_run++;
        if (m_busy_run >= MT) m_timeout = 1;
      end else begin
        m_busy_run = 0;
        if (m_flush_left > 0) m_flush_left--;
        else if (br_event) begin
          m_flush_left = FC - 1;
          if (m_flush < CMAX) m_flush++;
        end
      end
    end

    @(posedge clk_i);
    #1;
    check("timeout",   32'(timeout_o),   32'(m_timeout));
    check("stall_cnt", 32'(stall_cnt_o), 32'(m_stall));
    check("flush_cnt", 32'(flush_cnt_o), 32'(m_flush));
  endtask

  // Asynchronous reset pulse taken mid-cycle; returns at posedge+1.
  task automatic do_reset();
    rst_n_i = 1'b0;
    #1;
    check("rst_pc_write",  32'(pc_write_o),  32'd0);
    check("rst_hazard",    32'(hazard_o),    32'd0);
    check("rst_flush",     32'(flush_o),     32'd0);
    check("rst_bubble",    32'(bubble_o),    32'd0);
    check("rst_freeze",    32'(freeze_o),    32'd0);
    check("rst_timeout",   32'(timeout_o),   32'd0);
    check("rst_stall_cnt", 32'(stall_cnt_o), 32'd0);
    check("rst_flush_cnt", 32'(flush_cnt_o), 32'd0);
    model_reset();
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
  endtask

  initial begin
    model_reset();
    rst_n_i = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk_i);
    #1;
    do_reset();

    // Bring-up: IDLE cycle then normal RUN.
    drive(1, 0, 0, 0, 0, 1, 2); tick();
    drive(1, 0, 0, 0, 0, 1, 2); tick();

    // Load-use on rs2, then a load to x0 which must not stall.
    drive(1, 0, 0, 1, 5, 3, 5); tick();
    check("loaduse_stall_cnt", 32'(stall_cnt_o), 32'd1);
    drive(1, 0, 0, 1, 0, 0, 0); tick();
    check("x0_no_stall", 32'(stall_cnt_o), 32'd1);

    // Branch pulse, second branch during the flush window is ignored.
    flush_hi_seen = 0;
    drive(1, 0, 1, 0, 0, 1, 2); tick();
    drive(1, 0, 1, 0, 0, 1, 2); tick();
    drive(1, 0, 0, 0, 0, 1, 2); tick();
    drive(1, 0, 0, 0, 0, 1, 2); tick();
    check("flush_width", 32'(flush_hi_seen), 32'd3);
    check("flush_cnt_one", 32'(flush_cnt_o), 32'd1);

    // Memory busy for 4 cycles while one flush cycle is still owed.
    drive(1, 0, 1, 0, 0, 1, 2); tick();
    drive(1, 0, 0, 0, 0, 1, 2); tick();
    repeat (4) begin drive(1, 1, 0, 0, 0, 1, 2); tick(); end
    drive(1, 0, 0, 0, 0, 1, 2); tick();
    drive(1, 0, 0, 0, 0, 1, 2); tick();
    check("busy_flush_stall", 32'(stall_cnt_o), 32'd5);

    // Long memory wait: timeout after the 8th busy cycle, sticky until stop.
    repeat (10) begin drive(1, 1, 1, 1, 4, 4, 4); tick(); end
    check("timeout_set", 32'(timeout_o), 32'd1);
    check("stall_sat_edge", 32'(stall_cnt_o), 32'(CMAX));
    drive(1, 0, 0, 0, 0, 1, 2); tick();
    drive(1, 0, 0, 1, 7, 7, 0); tick();
    check("stall_saturated", 32'(stall_cnt_o), 32'(CMAX));
    drive(0, 0, 0, 0, 0, 1, 2); tick();
    check("timeout_cleared", 32'(timeout_o), 32'd0);
    drive(1, 0, 0, 0, 0, 1, 2); tick();

    // Load-use and taken branch together: stall only.
    drive(1, 0, 0, 0, 0, 1, 2); tick();
    drive(1, 0, 1, 1, 6, 6, 1); tick();
    check("lu_br_flush_cnt", 32'(flush_cnt_o), 32'd2);

    // Reset in the second flush cycle.
    drive(1, 0, 1, 0, 0, 1, 2); tick();
    drive(1, 0, 0, 0, 0, 1, 2);
    #1;
    check("midflush_flush", 32'(flush_o), 32'd1);
    do_reset();

    // Random traffic with occasional stops and resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end
      drive($urandom_range(0, 49) != 0,
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 2) == 0,
            int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
